// File: rtl/fb_uart_dump.sv
// rtl/fb_uart_dump.sv - framebuffer row reader that dumps the image as ASCII art over UART TX
module fb_uart_dump #(
  parameter int          WIDTH    = 80,
  parameter int          ROWS     = 60,
  parameter int          BAUD_DIV = 104,
  parameter logic [7:0]  ON_CHAR  = 8'h23,
  parameter logic [7:0]  OFF_CHAR = 8'h2E
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [6:0]       rd_row_o,
  input  logic [WIDTH-1:0] rd_data_i,
  output logic             tx_o
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_PIX, S_CR, S_LF, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    col_q, col_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic [6:0]       row_q, row_d;

  logic             sending;
  logic             bit_end;
  logic             char_end;
  logic [7:0]       char_byte;
  logic [9:0]       frame;

  // tx is decoded from registered state, so an async reset forces it high at once
  always_comb begin
    sending   = (state_q == S_PIX) || (state_q == S_CR) || (state_q == S_LF);
    bit_end   = (baud_q == BW'(BAUD_DIV - 1));
    char_end  = bit_end && (bit_q == 4'd9);
    char_byte = 8'h0A;
    case (state_q)
      S_PIX:   char_byte = shreg_q[WIDTH-1] ? ON_CHAR : OFF_CHAR;
      S_CR:    char_byte = 8'h0D;
      default: char_byte = 8'h0A;
    endcase
    frame = {1'b1, char_byte, 1'b0};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      col_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      col_q   <= col_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    col_d   = col_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    row_d   = row_q;

    if (sending) begin
      if (bit_end) begin
        baud_d = '0;
        bit_d  = (bit_q == 4'd9) ? 4'd0 : bit_q + 4'd1;
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          row_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
        shreg_d = rd_data_i;
        col_d   = '0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_PIX;
      end
      S_PIX: begin
        if (char_end) begin
          shreg_d = shreg_q << 1;
          col_d   = col_q + CW'(1);
          if (col_q == CW'(WIDTH - 1)) state_d = S_CR;
        end
      end
      S_CR: begin
        if (char_end) state_d = S_LF;
      end
      S_LF: begin
        if (char_end) begin
          if (row_q == 7'(ROWS - 1)) begin
            state_d = S_FIN;
          end else begin
            row_d   = row_q + 7'd1;
            state_d = S_READ;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != S_IDLE) && (state_q != S_FIN);
    done_o   = (state_q == S_FIN);
    rd_en_o  = (state_q == S_READ);
    rd_row_o = row_q;
    tx_o     = sending ? frame[bit_q] : 1'b1;
  end

endmodule

// File: tb/tb_fb_uart_dump.sv
// tb/tb_fb_uart_dump.sv - scoreboard bench for fb_uart_dump on a 4x2 frame at 4 clocks per bit
module tb_fb_uart_dump;

  localparam int W = 4;
  localparam int R = 2;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic         busy, done, rd_en, tx;
  logic [6:0]   rd_row;
  logic [W-1:0] rd_data = '0;
  logic [W-1:0] mem [0:R-1];

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  fb_uart_dump #(.WIDTH(W), .ROWS(R), .BAUD_DIV(B), .ON_CHAR(8'h23), .OFF_CHAR(8'h2E)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .rd_en_o   (rd_en),
    .rd_row_o  (rd_row),
    .rd_data_i (rd_data),
    .tx_o      (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_row[0]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < W; c++) exp_q.push_back(mem[r][W-1-c] ? 8'h23 : 8'h2E);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART receiver: samples mid-bit on negedges, drops any character cut by reset
  logic [7:0] rx_b;
  bit         rx_ok;
  logic       rx_stop;
  always begin
    @(negedge clk);
    if (rstn === 1'b1 && tx === 1'b0) begin
      rx_ok = 1'b1;
      repeat (2) @(negedge clk);
      if (!rstn) rx_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        if (!rstn) rx_ok = 1'b0;
        rx_b[i] = tx;
      end
      repeat (4) @(negedge clk);
      if (!rstn) rx_ok = 1'b0;
      rx_stop = tx;
      if (rx_ok) begin
        check("stop_bit", {31'd0, rx_stop}, 32'd1);
        if (exp_q.size() == 0) check("unexpected_char", {24'd0, rx_b}, 32'hFFFF);
        else check("rx_char", {24'd0, rx_b}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic run_dump(input int sec_k, input int coh_k, input int rst_k);
    int         done_k, n_done, n_rd;
    int         rows[$];
    logic [7:0] first_ch;
    logic [9:0] fr;
    done_k = -1; n_done = 0; n_rd = 0;
    first_ch = mem[0][W-1] ? 8'h23 : 8'h2E;
    fr = {1'b1, first_ch, 1'b0};
    push_row(0);
    if (rst_k < 0) push_row(1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      if (k == sec_k) start = 1'b1;
      if (k == sec_k + 1) start = 1'b0;
      if (k == coh_k) mem[0] = ~mem[0];
      if (k == 1) check("busy_in_read", {31'd0, busy}, 32'd1);
      if (k == 2) check("rd_en_one_cycle", {31'd0, rd_en}, 32'd0);
      if (k >= 3 && k <= 42) check("first_char_bit", {31'd0, tx}, {31'd0, fr[(k-3)/4]});
      if (rd_en) begin
        n_rd++;
        rows.push_back(int'(rd_row));
      end
      if (done) begin
        n_done++;
        done_k = k;
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
      if (k == rst_k) begin
        check("tx_before_reset", {31'd0, tx}, 32'd0);
        rstn = 1'b0;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_rd_row", {25'd0, rd_row}, 32'd0);
      end
      if (k == rst_k + 10) rstn = 1'b1;
      @(posedge clk); #1;
    end
    check("rd_en_count", n_rd, 2);
    check("rd_row_seq", (rows.size() == 2) ? {rows[0][15:0], rows[1][15:0]} : 32'hDEAD, 32'h0000_0001);
    if (rst_k < 0) begin
      check("done_count", n_done, 1);
      check("done_cycle", done_k, 485);
    end else begin
      check("no_done_after_reset", n_done, 0);
    end
    check("chars_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    bit tx_low;
    rstn  = 1'b0;
    start = 1'b0;
    mem[0] = 4'b1001;
    mem[1] = 4'b0110;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rd_en", {31'd0, rd_en}, 32'd0);
    check("reset_rd_row", {25'd0, rd_row}, 32'd0);
    rstn = 1'b1;
    tx_low = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) tx_low = 1'b1;
    end
    check("idle_tx_high", {31'd0, tx_low}, 32'd0);

    run_dump(-10, -10, -100);
    run_dump(100, -10, -100);
    mem[0] = 4'b1100;
    mem[1] = 4'b0011;
    run_dump(-10, 3, -100);
    mem[0] = 4'b1001;
    mem[1] = 4'b0110;
    run_dump(-10, -10, 251);
    run_dump(-10, -10, -100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_uart_dump.md
# fb_uart_dump

Framebuffer read-back block for the cellular-automaton VGA design. On a start pulse it reads every row of the 60×80 image memory that the automaton writes, in order. It transmits each row over a UART TX line as ASCII art: one character per cell, then CR LF. It is the reader/serializer counterpart to the automaton's row writer, and it gives the bench and the host a text dump of the displayed frame.

## Interface
Parameters:
- WIDTH, 80: cells per row, which is the bit width of a memory word.
- ROWS, 60: rows per frame.
- BAUD_DIV, 104: clk cycles per UART bit (12 MHz / 115200).
- ON_CHAR, 8'h23: character sent for a cell with value 1 ('#').
- OFF_CHAR, 8'h2E: character sent for a cell with value 0 ('.').

Ports:
- clk, input, 1: system clock. One clock domain; reset is asynchronous and active-low.
- rstn, input, 1: asynchronous active-low reset.
- start, input, 1: 1-cycle pulse that requests a frame dump.
- busy, output, 1: high while a dump is in progress.
- done, output, 1: 1-cycle pulse when the final LF stop bit completes.
- rd_en, output, 1: read strobe to the image memory.
- rd_row, output, 7: row address (0..ROWS-1).
- rd_data, input, WIDTH: row word. It is valid on the cycle after rd_en is high.
- tx, output, 1: UART serial out. Idle level is 1.

## Operation
- Reset values: busy=0, done=0, rd_en=0, rd_row=0, tx=1, state=IDLE.
- State machine:
  - IDLE. If start=1: rd_row←0, busy←1, go to READ. Any other input is ignored.
  - READ. rd_en=1 for exactly one cycle at the current rd_row. Go to LATCH.
  - LATCH. Shift register←rd_data, col←0. Go to PIX.
  - PIX. Send one character per cell: ON_CHAR if the cell bit is 1, otherwise OFF_CHAR. Column 0 is bit WIDTH-1 and is sent first; bits follow MSB→LSB. After column WIDTH-1, go to CR.
  - CR. Send 8'h0D, then go to LF.
  - LF. Send 8'h0A. If rd_row==ROWS-1, go to FIN. Otherwise rd_row←rd_row+1 and go to READ.
  - FIN. done=1 and busy=0 in this cycle. Go to IDLE.
- Character framing:
  - One start bit (0), 8 data bits LSB first, one stop bit (1). Each bit lasts exactly BAUD_DIV cycles.
  - A character therefore lasts exactly 10·BAUD_DIV cycles.
  - No idle gap between characters within a row.
- start pulses while busy=1 are ignored. They are not queued.
- The row word is captured once in LATCH. Memory changes during the row's transmission do not affect the characters sent.
- The counters are sized for their own limits:
  - baud counter: clog2(BAUD_DIV) bits.
  - bit index: 4 bits.
  - column counter: clog2(WIDTH) bits.
  - rd_row: 7 bits.
- rd_row never exceeds ROWS-1.
- Reset asserted mid-dump:
  - All outputs return to their reset values immediately (asynchronously).
  - tx goes to 1 even if it is in the middle of a character.
  - done is not pulsed.
  - After release the block sits in IDLE and waits for a new start.

## Timing
- tx start bit of the first character begins 3 cycles after the start-pulse cycle: IDLE→READ→LATCH→first bit.
- Per row: 2 cycles (READ, LATCH) plus (WIDTH+2)·10·BAUD_DIV cycles.
- Whole frame: from the start cycle to the done pulse is 1 + ROWS·(2 + (WIDTH+2)·10·BAUD_DIV) cycles.
  - With the default parameters this is 1 + 60·(2 + 85 280) = 5 116 921 cycles.
- Between rows, tx is held at 1 for the 2 READ/LATCH cycles.
- done is high for exactly one cycle. busy falls in that same cycle. A new start is accepted on the following cycle.
- rd_en pulses exactly ROWS times per dump, with rd_row = 0, 1, …, ROWS-1 in order.

## Test plan
- Reset check: assert rstn=0 → tx=1, busy=0, done=0, rd_en=0, rd_row=0. Release rstn, apply no start for 1000 cycles → tx stays 1.
- Single small frame (WIDTH=4, ROWS=2, BAUD_DIV=4); memory row0=4'b1001, row1=4'b0110; pulse start.
  - UART decode gives exactly "#..#\r\n.##.\r\n".
  - Each bit lasts 4 cycles.
  - done pulses on cycle 1+2·(2+240)=485 after start.
- Character framing, same parameters: bit-level sampling of the first character shows 0, then 0x23 LSB-first (1,1,0,0,0,1,0,0), then 1. Total 40 cycles.
- Start while busy: second start pulse 100 cycles into a dump → only one dump transmitted and one done pulse. rd_en count = ROWS.
- Reset mid-character: assert rstn during a data bit of row 1 → tx=1 immediately, busy=0, no done. A new start then produces a complete, correct dump from row 0.
- Memory coherence: change row0 in memory one cycle after its LATCH → transmitted row0 matches the pre-change value. rd_row sequence is 0,1 and rd_data is sampled one cycle after rd_en.
